pixel_stream_packer: RTL

//  Downstream of the shading stage: takes one 24-bit RGB shade (plus hit flag) per valid cycle in raster order.

---
 rtl/pixel_stream_packer_pkg.sv | 23 ++
 rtl/pixel_stream_packer_sync_fifo.sv | 59 +++++
 rtl/pixel_stream_packer.sv | 112 +++++++++++
 3 files changed

// File: rtl/pixel_stream_packer_pkg.sv
// Shared types for the pixel stream packer: colour word, FIFO entry layout
// and the hit/background colour selection.
package pixel_stream_packer_pkg;

    localparam int RGB_W = 24;

    typedef logic [RGB_W-1:0] rgb_t;

    localparam rgb_t BG_COLOUR_DEFAULT = 24'h000000;

    typedef struct packed {
        logic sof;
        logic eol;
        rgb_t colour;
    } pix_t;

    localparam int PIX_W = $bits(pix_t);

    function automatic rgb_t select_colour(input logic hit, input rgb_t shade, input rgb_t bg);
        return hit ? shade : bg;
    endfunction

endpackage

// File: rtl/pixel_stream_packer_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is always on rd_data.
// Storage is unreset, only pointers and occupancy are cleared by rst.
module sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign count   = count_q;
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/pixel_stream_packer.sv
// Packs shaded pixels into an AXI4-Stream video stream with SOF/EOL tags,
// background substitution, back-pressure buffering and overflow flagging.
module pixel_stream_packer
    import pixel_stream_packer_pkg::*;
#(
    parameter int   SCREEN_WIDTH  = 640,
    parameter int   SCREEN_HEIGHT = 480,
    parameter int   FIFO_DEPTH    = 8,
    parameter rgb_t BG_COLOUR     = BG_COLOUR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        hit_in,
    input  logic [23:0] shade_in,
    output logic        ready_out,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        frame_done,
    output logic        overflow
);

    localparam int XW = $clog2(SCREEN_WIDTH);
    localparam int YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [XW-1:0] X_LAST = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_HEIGHT - 1);

    logic [XW-1:0] x_p0;
    logic [YW-1:0] y_p0;
    logic [YW-1:0] line_p1;
    pix_t          push_pix_p0;
    pix_t          head_pix_p1;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          accept_p0;
    logic          pop_p1;

    // Input side: raster position tracking and tagging
    assign ready_out   = (fifo_count < CW'(FIFO_DEPTH));
    assign accept_p0   = valid_in & ~fifo_full;
    assign push_pix_p0 = '{sof:    (x_p0 == '0) && (y_p0 == '0),
                           eol:    (x_p0 == X_LAST),
                           colour: select_colour(hit_in, shade_in, BG_COLOUR)};

    always_ff @(posedge clk) begin
        if (rst) begin
            x_p0 <= '0;
            y_p0 <= '0;
        end else if (accept_p0) begin
            if (x_p0 == X_LAST) begin
                x_p0 <= '0;
                y_p0 <= (y_p0 == Y_LAST) ? '0 : y_p0 + 1'b1;
            end else begin
                x_p0 <= x_p0 + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (valid_in && !ready_out) begin
            overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept_p0),
        .wr_data (push_pix_p0),
        .rd_en   (pop_p1),
        .rd_data (head_pix_p1),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Output side: AXIS head, line tracking and end-of-frame pulse
    assign m_axis_tvalid = ~fifo_empty;
    assign pop_p1        = m_axis_tvalid & m_axis_tready;
    assign m_axis_tdata  = m_axis_tvalid ? head_pix_p1.colour : '0;
    assign m_axis_tuser  = m_axis_tvalid & head_pix_p1.sof;
    assign m_axis_tlast  = m_axis_tvalid & head_pix_p1.eol;

    always_ff @(posedge clk) begin
        if (rst) begin
            line_p1    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (pop_p1 && head_pix_p1.eol) begin
                if (line_p1 == Y_LAST) begin
                    line_p1    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    line_p1 <= line_p1 + 1'b1;
                end
            end
        end
    end

endmodule
